// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the programmable serial sequence detector:
// KMP next-state and self-overlap (failure) functions over a pattern of up to SEQ_LEN_MAX bits.
package seq_det_pkg;

  localparam int unsigned SEQ_LEN_MAX = 16;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pbit(input logic [SEQ_LEN_MAX-1:0] pattern,
                                input int unsigned len,
                                input int unsigned i);
    logic [SEQ_LEN_MAX-1:0] sh;
    sh = pattern >> (len - 1 - i);
    return sh[0];
  endfunction

  // Next matched-prefix length after consuming b with k bits already matched.
  function automatic int unsigned seq_next(input logic [SEQ_LEN_MAX-1:0] pattern,
                                           input int unsigned len,
                                           input int unsigned k,
                                           input logic b);
    int unsigned res;
    logic        ok;
    logic        sb;
    res = 0;
    if (k < len) begin
      if (b == pbit(pattern, len, k)) begin
        res = k + 1;
      end else begin
        // Longest pattern prefix that ends the string (matched k bits, b); ascending keeps the longest.
        for (int unsigned j = 1; j <= k; j++) begin
          ok = 1'b1;
          for (int unsigned t = 0; t < j; t++) begin
            sb = ((k + 1 - j + t) == k) ? b : pbit(pattern, len, k + 1 - j + t);
            if (pbit(pattern, len, t) != sb) ok = 1'b0;
          end
          if (ok) res = j;
        end
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the full pattern that is also its suffix.
  function automatic int unsigned seq_fail(input logic [SEQ_LEN_MAX-1:0] pattern,
                                           input int unsigned len);
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned j = 1; j < len; j++) begin
      ok = 1'b1;
      for (int unsigned t = 0; t < j; t++) begin
        if (pbit(pattern, len, t) != pbit(pattern, len, len - j + t)) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_prog.sv
// Parametrised Moore serial sequence detector with run-time overlap/non-overlap selection.
// Optional saturating match counter on det_cnt when SEQ_DET_COUNT_EN is defined.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned        SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101
`ifdef SEQ_DET_COUNT_EN
  ,
  parameter int unsigned        CNT_W   = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             ovl,
  output logic             z
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  localparam int unsigned     SW     = $clog2(SEQ_LEN + 1);
  localparam int unsigned     DEPTH  = 1 << SW;
  localparam logic [SW-1:0]   LAST   = SW'(SEQ_LEN);
  localparam logic [SW-1:0]   OVL_ST = SW'(seq_fail(SEQ_LEN_MAX'(PATTERN), SEQ_LEN));

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [SW-1:0] base;
  logic [SW-1:0] tbl0 [DEPTH];
  logic [SW-1:0] tbl1 [DEPTH];

  // Transition tables folded to constants at elaboration; entries at or above SEQ_LEN are 0.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    assign tbl0[k] = SW'(seq_next(SEQ_LEN_MAX'(PATTERN), SEQ_LEN, k, 1'b0));
    assign tbl1[k] = SW'(seq_next(SEQ_LEN_MAX'(PATTERN), SEQ_LEN, k, 1'b1));
  end

  // Next state: a full match restarts from the overlap state or from zero, depending on ovl.
  always_comb begin
    state_nxt = state;
    base      = '0;
    if (en) begin
      if (state == LAST) base = ovl ? OVL_ST : '0;
      else               base = state;
      if (state > LAST) state_nxt = '0;
      else              state_nxt = x ? tbl1[base] : tbl0[base];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= (state_nxt == LAST);
    end
  end

`ifdef SEQ_DET_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_cnt <= '0;
    end else if (en && (state_nxt == LAST) && (det_cnt != '1)) begin
      det_cnt <= det_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: 1101 detector plus a 101010 instance for the length sweep.
module tb_seq_det_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic x   = 1'b0;
  logic ovl = 1'b1;
  logic z4;
  logic z6;
  int   cmp  = 0;
  int   errs = 0;

`ifdef SEQ_DET_COUNT_EN
  logic [1:0] cnt4;
  logic [7:0] cnt6;
`endif

  always #5 clk = ~clk;

  seq_det_prog #(
    .SEQ_LEN(4),
    .PATTERN(4'b1101)
`ifdef SEQ_DET_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut4 (
    .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .z(z4)
`ifdef SEQ_DET_COUNT_EN
    , .det_cnt(cnt4)
`endif
  );

  seq_det_prog #(
    .SEQ_LEN(6),
    .PATTERN(6'b101010)
`ifdef SEQ_DET_COUNT_EN
    , .CNT_W(8)
`endif
  ) dut6 (
    .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .z(z6)
`ifdef SEQ_DET_COUNT_EN
    , .det_cnt(cnt6)
`endif
  );

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    x   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one bit for one clock edge; returns #1 after that edge.
  task automatic push(input logic e, input logic b);
    en = e;
    x  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] xs = 4'b1101;
    logic [3:0] zs = 4'b0001;
    do_reset();
    cmp++;
    if (z4 !== 1'b0 || z6 !== 1'b0) begin
      errs++;
      $display("FAIL reset_state z4=%b z6=%b expected 0 0", z4, z6);
    end
`ifdef SEQ_DET_COUNT_EN
    cmp++;
    if (cnt4 !== 2'd0) begin
      errs++;
      $display("FAIL reset_cnt det_cnt=%0d expected 0", cnt4);
    end
`endif
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    push(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    cmp++;
    if (z4 !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid z=%b expected 0", z4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // A lingering partial match would complete on this first 1.
    for (int i = 3; i >= 0; i--) begin
      push(1'b1, xs[i]);
      cmp++;
      if (z4 !== zs[i]) begin
        errs++;
        $display("FAIL reset_rematch bit%0d z=%b expected %b", 4 - i, z4, zs[i]);
      end
    end
    rst = 1'b1;
    #1;
    cmp++;
    if (z4 !== 1'b0) begin
      errs++;
      $display("FAIL reset_async z=%b expected 0", z4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_overlap();
    logic [6:0] xs = 7'b1101101;
    logic [6:0] zs = 7'b0001001;
    do_reset();
    ovl = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      push(1'b1, xs[i]);
      cmp++;
      if (z4 !== zs[i]) begin
        errs++;
        $display("FAIL overlap bit%0d z=%b expected %b", 7 - i, z4, zs[i]);
      end
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] xa = 7'b1101101;
    logic [6:0] za = 7'b0001000;
    logic [7:0] xb = 8'b11011101;
    logic [7:0] zb = 8'b00010001;
    do_reset();
    ovl = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      push(1'b1, xa[i]);
      cmp++;
      if (z4 !== za[i]) begin
        errs++;
        $display("FAIL nonoverlap_a bit%0d z=%b expected %b", 7 - i, z4, za[i]);
      end
    end
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      push(1'b1, xb[i]);
      cmp++;
      if (z4 !== zb[i]) begin
        errs++;
        $display("FAIL nonoverlap_b bit%0d z=%b expected %b", 8 - i, z4, zb[i]);
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic [2:0] xs = 3'b101;
    do_reset();
    ovl = 1'b1;
    push(1'b1, 1'b1);
    push(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, i[0]);
      cmp++;
      if (z4 !== 1'b0) begin
        errs++;
        $display("FAIL gap_hold%0d z=%b expected 0", i, z4);
      end
    end
    push(1'b1, 1'b0);
    push(1'b1, 1'b1);
    cmp++;
    if (z4 !== 1'b1) begin
      errs++;
      $display("FAIL gap_match z=%b expected 1", z4);
    end
    // Stall after the match; ovl flips to 0 here and must not disturb the held state.
    for (int i = 0; i < 3; i++) begin
      ovl = 1'b0;
      push(1'b0, ~i[0]);
      cmp++;
      if (z4 !== 1'b1) begin
        errs++;
        $display("FAIL stall_hold%0d z=%b expected 1", i, z4);
      end
    end
    // Non-overlapping restart: 1,0,1 must not complete a second match.
    for (int i = 2; i >= 0; i--) begin
      push(1'b1, xs[i]);
      cmp++;
      if (z4 !== 1'b0) begin
        errs++;
        $display("FAIL mode_change bit%0d z=%b expected 0", 3 - i, z4);
      end
    end
  endtask

  task automatic test_param6();
    logic [9:0] xs  = 10'b1010101010;
    logic [9:0] zo  = 10'b0000010101;
    logic [9:0] zn  = 10'b0000010000;
    do_reset();
    ovl = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      push(1'b1, xs[i]);
      cmp++;
      if (z6 !== zo[i]) begin
        errs++;
        $display("FAIL len6_ovl bit%0d z=%b expected %b", 10 - i, z6, zo[i]);
      end
    end
    do_reset();
    ovl = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      push(1'b1, xs[i]);
      cmp++;
      if (z6 !== zn[i]) begin
        errs++;
        $display("FAIL len6_novl bit%0d z=%b expected %b", 10 - i, z6, zn[i]);
      end
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic test_count();
    logic [15:0] xs = 16'b1101101101101101;
    int          exp_cnt;
    do_reset();
    ovl = 1'b1;
    exp_cnt = 0;
    for (int i = 15; i >= 0; i--) begin
      push(1'b1, xs[i]);
      if ((16 - i) >= 4 && ((16 - i - 4) % 3) == 0 && exp_cnt < 3) exp_cnt++;
      cmp++;
      if (cnt4 !== 2'(exp_cnt)) begin
        errs++;
        $display("FAIL count bit%0d det_cnt=%0d expected %0d", 16 - i, cnt4, exp_cnt);
      end
    end
    rst = 1'b1;
    #1;
    cmp++;
    if (cnt4 !== 2'd0) begin
      errs++;
      $display("FAIL count_clear det_cnt=%0d expected 0", cnt4);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_enable_gaps();
    test_param6();
`ifdef SEQ_DET_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
